// File: rtl/mux8to1_rr_arbiter.sv
// mux8to1_rr_arbiter
// Round-robin arbiter that owns the select of an 8:1 registered output mux.
// Eight producers raise req while they have data. The arbiter grants one of
// them at a time (one-hot grant plus 3-bit select) and moves one data beat
// per cycle from the granted slice into the out register.
//
// A hold counter limits each grant to MAX_HOLD consecutive beats. The rotation
// pointer then moves past the holder, so every requester is served fairly.
//
// A release re-arbitrates on the same edge. Switching from one requester to
// the next therefore costs no idle grant cycle. If the holder was the only
// requester, it is re-granted at once and the beat stream stays gap-free.

module mux8to1_rr_arbiter #(
    parameter int               WIDTH       = 1,
    parameter int               MAX_HOLD    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           req,
    input  logic [8*WIDTH-1:0]   in,
    output logic [7:0]           grant,
    output logic [2:0]           select,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [2:0]           out_src
);

    // Counter wide enough to hold values 0..MAX_HOLD.
    localparam int HW = $clog2(MAX_HOLD + 1);

    // Count value at which the next beat is the last one of the burst.
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_r;
    logic [2:0]     ptr_r;
    logic [HW-1:0]  hold_cnt_r;

    logic           beat_s;
    logic           release_s;
    logic [2:0]     scan_ptr_s;
    logic [3:0]     win_s;
    logic [WIDTH-1:0] slice_s;

    // Rotating priority search.
    // Returns {found, index} for the first requester at or after p, modulo 8.
    // The loop runs from the farthest position back to p. The last hit
    // written is therefore the one closest to p, so no early exit is needed.
    function automatic logic [3:0] find_winner(input logic [7:0] r,
                                                input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Classify this cycle and pick the scan start.
    // In GRANT: a beat is a cycle where the holder still requests. A release
    // happens when the holder drops req, or when it takes its last allowed
    // beat. After a release, the scan starts one past the holder.
    // In IDLE: the scan starts at the stored pointer.
    always_comb begin
        beat_s     = 1'b0;
        release_s  = 1'b0;
        scan_ptr_s = ptr_r;
        if (state_r == GRANT) begin
            beat_s = req[select];
            if (!req[select]) begin
                release_s = 1'b1;
            end else if (hold_cnt_r == HOLD_LAST) begin
                release_s = 1'b1;
            end else begin
                release_s = 1'b0;
            end
            if (release_s) begin
                scan_ptr_s = select + 3'd1;
            end else begin
                scan_ptr_s = ptr_r;
            end
        end else begin
            beat_s     = 1'b0;
            release_s  = 1'b0;
            scan_ptr_s = ptr_r;
        end
    end

    // Arbitration winner against the current request vector.
    always_comb begin
        win_s = find_winner(req, scan_ptr_s);
    end

    // 8:1 data mux driven by the registered select.
    always_comb begin
        slice_s = '0;
        for (int i = 0; i < 8; i++) begin
            if (select == 3'(i)) begin
                slice_s = in[i*WIDTH +: WIDTH];
            end else begin
                slice_s = slice_s;
            end
        end
    end

    // Grant FSM, rotation pointer, hold counter and output data register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            ptr_r      <= 3'd0;
            hold_cnt_r <= '0;
            grant      <= 8'h00;
            select     <= 3'd0;
            out        <= RESET_VALUE;
            out_valid  <= 1'b0;
            out_src    <= 3'd0;
        end else begin
            // Data path. out and out_src change only on a beat.
            // out_valid marks exactly the beat cycles.
            if (beat_s) begin
                out       <= slice_s;
                out_src   <= select;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (win_s[3]) begin
                        grant      <= 8'h01 << win_s[2:0];
                        select     <= win_s[2:0];
                        hold_cnt_r <= '0;
                        state_r    <= GRANT;
                    end
                end

                GRANT: begin
                    if (release_s) begin
                        ptr_r <= scan_ptr_s;
                        if (win_s[3]) begin
                            // Hand over on the same edge; may re-grant the holder.
                            grant      <= 8'h01 << win_s[2:0];
                            select     <= win_s[2:0];
                            hold_cnt_r <= '0;
                            state_r    <= GRANT;
                        end else begin
                            grant      <= 8'h00;
                            select     <= 3'd0;
                            hold_cnt_r <= '0;
                            state_r    <= IDLE;
                        end
                    end else if (beat_s) begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a clean idle state.
                    grant      <= 8'h00;
                    select     <= 3'd0;
                    hold_cnt_r <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux8to1_rr_arbiter.md
Name: mux8to1_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered WIDTH-bit output bus among 8 requesters.
- It owns the 3-bit select of an 8:1 output register, issues one-hot grants and bounds burst length with a hold counter.
- It sits between 8 producer blocks and a single downstream consumer in place of a free-running select.

Parameters:
- WIDTH, 1: data width per requester slice.
- MAX_HOLD, 4: maximum consecutive beats per grant. Must be >=1; 1 means beat-by-beat rotation.
- RESET_VALUE, 0: value loaded into out on reset (WIDTH bits).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  8  request per requester i; held high while it has data.
- in  in  8*WIDTH  requester data; slice i is in[(i+1)*WIDTH-1 : i*WIDTH].
- grant  out  8  registered one-hot grant; all zero when idle.
- select  out  3  registered index of current grant; 0 when idle.
- out  out  WIDTH  registered data of last accepted beat.
- out_valid  out  1  high for one cycle per accepted beat.
- out_src  out  3  requester index that produced out.

Behaviour:
- Reset (reset=0, async, any time including mid-burst):
  - grant=0, select=0, out=RESET_VALUE, out_valid=0, out_src=0.
  - Internal pointer ptr=0, hold_cnt=0, state=IDLE. Takes effect without waiting for a clock edge.
- States: IDLE (grant=0) and GRANT (exactly one grant bit set).
- Arbitration function: winner = first i with req[i]=1 scanning ptr, ptr+1, ..., ptr+7 mod 8. None if req=0.
- IDLE, each edge:
  - If a winner exists: grant<=onehot(winner), select<=winner, hold_cnt<=0, state<=GRANT.
  - Else remain IDLE.
- Beat: a rising edge in GRANT with req[select]=1.
  - Loads out<=slice select, out_src<=select, out_valid<=1, hold_cnt<=hold_cnt+1.
  - Every edge that is not a beat drives out_valid<=0; out and out_src hold.
- Release conditions in GRANT at an edge:
  - (a) req[select]=0: no beat.
  - (b) Beat with hold_cnt=MAX_HOLD-1: the beat is taken.
- On release, at the same edge:
  - ptr<=select+1 mod 8.
  - Re-arbitrate using the new ptr against the current req.
  - Winner found: grant/select load the winner, hold_cnt<=0, stay GRANT. No idle cycle on grant switch.
  - No winner: grant<=0, select<=0, state<=IDLE.
- Forced release (b) with the holder the sole requester re-grants the same requester with hold_cnt reset. Beats stay back-to-back, with no out_valid gap.
- Release (a) costs one out_valid-low cycle before the next requester's first beat.
- Latency:
  - req rises in IDLE: grant after 1 edge; first out_valid after 2 edges.
  - Sustained: one beat per cycle.
- Requests to non-granted requesters are ignored and not queued; requesters hold req until granted.
- Wrap-around: ptr increments mod 8, so a release from 7 scans from 0.
- hold_cnt is ceil(log2(MAX_HOLD+1)) bits and never exceeds MAX_HOLD-1 between beats.
- in is sampled only at beat edges; changes at other times do not affect out.

Test Plan:
1. Reset: drive reset=0 mid-simulation with clock stopped -> grant=0, select=0, out=RESET_VALUE, out_valid=0 immediately. Release with req=0x00 -> stays IDLE, outputs unchanged.
2. Single requester: WIDTH=8, req=0x04, slice2=0xA5 -> edge1 grant=0x04, select=2; edge2 out=0xA5, out_valid=1, out_src=2. out_valid stays 1 across the MAX_HOLD=4 boundary, with no gap, for 10 cycles.
3. Full rotation: req=0xFF held, slice i=0x10+i, MAX_HOLD=4 -> out sequence 0x10 x4, 0x11 x4, ..., 0x17 x4, then 0x10 again. No out_valid gaps.
4. Early drop: req=0x09, grant on 0. Drop req[0] after 2 beats -> next edge grant=0x08, with exactly one cycle out_valid=0. Then beats from requester 3, out_src=3.
5. Wrap: let requester 7 finish a burst with req=0x81 -> next grant=0x01 (ptr wrapped to 0), not 7 again.
6. Reset mid-burst: grant=0x20, hold_cnt=2, then reset low 1 cycle; after release req=0x21 -> first grant=0x01 (ptr=0), first out after 2 edges is slice 0.
